// File: rtl/l1_wr_port.sv
// Fill-side writer for the L1 multi-stream buffer: registers L2 fill beats and tracks per-stream line state.
// Optional sticky per-stream error flags (o_err) are enabled by defining L1_WR_ERR_CHK_EN.
module l1_wr_port #(
    parameter int nstrms       = 64,
    parameter int nstrms_width = $clog2(nstrms),
    parameter int ptr_width    = 1,
    parameter int cl_size      = 8,
    parameter int clofs_width  = $clog2(cl_size),
    parameter int data_width   = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [nstrms-1:0]               i_rst,
    input  logic                            i_fill_v,
    output logic                            i_fill_r,
    input  logic [nstrms_width-1:0]         i_fill_sid,
    input  logic [data_width-1:0]           i_fill_data,
    input  logic                            i_fill_last,
    output logic                            o_wr_v,
    input  logic                            o_wr_r,
    output logic [nstrms_width-1:0]         o_wr_sid,
    output logic [ptr_width-1:0]            o_wr_ptr,
    output logic [clofs_width-1:0]          o_wr_clofs,
    output logic [data_width-1:0]           o_wr_data,
    input  logic [nstrms-1:0]               i_rel,
    output logic [nstrms*(ptr_width+1)-1:0] o_nvalid,
    output logic [nstrms-1:0]               o_single_v,
    output logic [nstrms-1:0]               o_end
`ifdef L1_WR_ERR_CHK_EN
   ,output logic [nstrms-1:0]               o_err
`endif
);

    localparam logic [ptr_width+1:0] depth_l = {1'b0, 1'b1, {ptr_width{1'b0}}};

    logic [ptr_width-1:0]    wptr_all  [nstrms];
    logic [clofs_width-1:0]  clofs_all [nstrms];
    logic [ptr_width:0]      cnt_all   [nstrms];
    logic [nstrms-1:0]       end_all;

    logic                    wr_v_reg;
    logic [nstrms_width-1:0] wr_sid_reg;
    logic [ptr_width-1:0]    wr_ptr_reg;
    logic [clofs_width-1:0]  wr_clofs_reg;
    logic [data_width-1:0]   wr_data_reg;
    logic                    wr_last_reg;
    logic                    wr_close_reg;
    logic                    wr_stale_reg;

    logic                    reg_free;
    logic                    hs;
    logic                    commit;
    logic                    live;
    logic                    pending_line;
    logic                    end_pending;
    logic [ptr_width-1:0]    sel_ptr;
    logic [clofs_width-1:0]  sel_clofs;
    logic [ptr_width:0]      sel_cnt;
    logic [ptr_width+1:0]    occ;
    logic                    full;
    logic                    sel_close;
    logic                    accept;

    always_comb begin
        reg_free     = ~wr_v_reg | o_wr_r;
        hs           = wr_v_reg & o_wr_r;
        // A beat orphaned by a restart still reaches BRAM but must not touch stream state.
        commit       = hs & ~wr_stale_reg;
        live         = wr_v_reg & ~wr_stale_reg & (wr_sid_reg == i_fill_sid);
        pending_line = live & wr_close_reg;
        end_pending  = live & wr_last_reg;
        sel_ptr      = wptr_all[i_fill_sid];
        sel_clofs    = clofs_all[i_fill_sid];
        sel_cnt      = cnt_all[i_fill_sid];
        occ          = {1'b0, sel_cnt} + {{(ptr_width+1){1'b0}}, pending_line};
        full         = (occ == depth_l);
        sel_close    = (&sel_clofs) | i_fill_last;
        i_fill_r     = reg_free & ~full & ~i_rst[i_fill_sid] & ~end_all[i_fill_sid] & ~end_pending;
        accept       = i_fill_v & i_fill_r;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_v_reg     <= 1'b0;
            wr_sid_reg   <= '0;
            wr_ptr_reg   <= '0;
            wr_clofs_reg <= '0;
            wr_data_reg  <= '0;
            wr_last_reg  <= 1'b0;
            wr_close_reg <= 1'b0;
            wr_stale_reg <= 1'b0;
        end else if (accept) begin
            wr_v_reg     <= 1'b1;
            wr_sid_reg   <= i_fill_sid;
            wr_ptr_reg   <= sel_ptr;
            wr_clofs_reg <= sel_clofs;
            wr_data_reg  <= i_fill_data;
            wr_last_reg  <= i_fill_last;
            wr_close_reg <= sel_close;
            wr_stale_reg <= 1'b0;
        end else if (hs) begin
            wr_v_reg     <= 1'b0;
            wr_stale_reg <= 1'b0;
        end else if (wr_v_reg && i_rst[wr_sid_reg]) begin
            wr_stale_reg <= 1'b1;
        end
    end

    assign o_wr_v     = wr_v_reg;
    assign o_wr_sid   = wr_sid_reg;
    assign o_wr_ptr   = wr_ptr_reg;
    assign o_wr_clofs = wr_clofs_reg;
    assign o_wr_data  = wr_data_reg;

    generate
        for (genvar gi = 0; gi < nstrms; gi++) begin : gen_strm
            logic [ptr_width-1:0]   wptr_reg;
            logic [clofs_width-1:0] clofs_reg;
            logic [ptr_width:0]     cnt_reg;
            logic                   end_reg;
            logic                   hit_in;
            logic                   inc;
            logic                   dec;

            assign hit_in = accept & (i_fill_sid == nstrms_width'(gi));
            assign inc    = commit & wr_close_reg & (wr_sid_reg == nstrms_width'(gi));
            // Releasing an empty stream is dropped so the count never wraps.
            assign dec    = i_rel[gi] & (|cnt_reg);

            always_ff @(posedge clk) begin
                if (!reset || i_rst[gi]) begin
                    wptr_reg  <= '0;
                    clofs_reg <= '0;
                    cnt_reg   <= '0;
                    end_reg   <= 1'b0;
                end else begin
                    if (hit_in) begin
                        clofs_reg <= clofs_reg + 1'b1;
                        if (sel_close)
                            wptr_reg <= wptr_reg + 1'b1;
                    end
                    cnt_reg <= cnt_reg + {{ptr_width{1'b0}}, inc} - {{ptr_width{1'b0}}, dec};
                    if (commit && wr_last_reg && wr_sid_reg == nstrms_width'(gi))
                        end_reg <= 1'b1;
                end
            end

            assign wptr_all[gi]  = wptr_reg;
            assign clofs_all[gi] = clofs_reg;
            assign cnt_all[gi]   = cnt_reg;
            assign end_all[gi]   = end_reg;
            assign o_nvalid[gi*(ptr_width+1) +: ptr_width+1] = cnt_reg;
            assign o_single_v[gi] = (cnt_reg == {{ptr_width{1'b0}}, 1'b1});
            assign o_end[gi]      = end_reg;

`ifdef L1_WR_ERR_CHK_EN
            logic err_reg;
            always_ff @(posedge clk) begin
                if (!reset || i_rst[gi])
                    err_reg <= 1'b0;
                else if ((i_rel[gi] && cnt_reg == '0) ||
                         (i_fill_v && i_fill_sid == nstrms_width'(gi) && end_reg))
                    err_reg <= 1'b1;
            end
            assign o_err[gi] = err_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_l1_wr_port.sv
// Directed testbench for l1_wr_port (default parameters); checks o_err when L1_WR_ERR_CHK_EN is defined.
module tb_l1_wr_port;

    localparam int NS = 64;
    localparam int SW = 6;
    localparam int PW = 1;
    localparam int CW = 3;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NS-1:0]     i_rst = '0;
    logic              i_fill_v = 1'b0;
    logic              i_fill_r;
    logic [SW-1:0]     i_fill_sid = '0;
    logic [DW-1:0]     i_fill_data = '0;
    logic              i_fill_last = 1'b0;
    logic              o_wr_v;
    logic              o_wr_r = 1'b1;
    logic [SW-1:0]     o_wr_sid;
    logic [PW-1:0]     o_wr_ptr;
    logic [CW-1:0]     o_wr_clofs;
    logic [DW-1:0]     o_wr_data;
    logic [NS-1:0]     i_rel = '0;
    logic [NS*(PW+1)-1:0] o_nvalid;
    logic [NS-1:0]     o_single_v;
    logic [NS-1:0]     o_end;
`ifdef L1_WR_ERR_CHK_EN
    logic [NS-1:0]     o_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int wr_count = 0;

    l1_wr_port dut (
        .clk(clk), .reset(reset), .i_rst(i_rst),
        .i_fill_v(i_fill_v), .i_fill_r(i_fill_r), .i_fill_sid(i_fill_sid),
        .i_fill_data(i_fill_data), .i_fill_last(i_fill_last),
        .o_wr_v(o_wr_v), .o_wr_r(o_wr_r), .o_wr_sid(o_wr_sid), .o_wr_ptr(o_wr_ptr),
        .o_wr_clofs(o_wr_clofs), .o_wr_data(o_wr_data), .i_rel(i_rel),
        .o_nvalid(o_nvalid), .o_single_v(o_single_v),
`ifdef L1_WR_ERR_CHK_EN
        .o_err(o_err),
`endif
        .o_end(o_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (o_wr_v && o_wr_r) wr_count++;

    function automatic logic [PW:0] nv(input int s);
        return o_nvalid[s*(PW+1) +: PW+1];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [SW-1:0] sid, input logic [DW-1:0] d, input logic l);
        i_fill_v = 1'b1; i_fill_sid = sid; i_fill_data = d; i_fill_last = l;
    endtask

    task automatic idle();
        i_fill_v = 1'b0; i_fill_last = 1'b0;
    endtask

    task automatic reset_dut();
        idle(); i_rst = '0; i_rel = '0; o_wr_r = 1'b1;
        reset = 1'b0; step(); step(); reset = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp += 4;
        if (o_wr_v !== 1'b0) begin n_err++; $display("FAIL reset_wr_v got %0b want 0", o_wr_v); end
        if (o_nvalid !== '0) begin n_err++; $display("FAIL reset_nvalid got %h want 0", o_nvalid); end
        if (o_single_v !== '0) begin n_err++; $display("FAIL reset_single got %h want 0", o_single_v); end
        if (o_end !== '0) begin n_err++; $display("FAIL reset_end got %h want 0", o_end); end
        drive(0, 0, 0); #1;
        n_cmp++;
        if (i_fill_r !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", i_fill_r); end
        idle();
        $display("test_reset done");
    endtask

    task automatic test_full_line();
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            drive(3, 64'(k), 0); #1;
            n_cmp++;
            if (i_fill_r !== 1'b1) begin n_err++; $display("FAIL line_ready beat %0d got %0b want 1", k, i_fill_r); end
            step();
            n_cmp++;
            if (o_wr_v !== 1'b1 || o_wr_sid !== 6'd3 || o_wr_ptr !== 1'b0 || o_wr_clofs !== 3'(k) || o_wr_data !== 64'(k)) begin
                n_err++;
                $display("FAIL line_write beat %0d got v%0b sid%0d ptr%0d ofs%0d d%0h want v1 sid3 ptr0 ofs%0d d%0h",
                         k, o_wr_v, o_wr_sid, o_wr_ptr, o_wr_clofs, o_wr_data, k, k);
            end
            $display("stream3 beat %0d ptr %0d clofs %0d", k, o_wr_ptr, o_wr_clofs);
        end
        idle();
        n_cmp++;
        if (nv(3) !== 2'd0) begin n_err++; $display("FAIL line_cnt_early got %0d want 0", nv(3)); end
        step();
        n_cmp += 2;
        if (nv(3) !== 2'd1) begin n_err++; $display("FAIL line_cnt got %0d want 1", nv(3)); end
        if (o_single_v[3] !== 1'b1) begin n_err++; $display("FAIL line_single got %0b want 1", o_single_v[3]); end
    endtask

    task automatic test_full();
        reset_dut();
        for (int k = 0; k < 16; k++) begin
            drive(5, 64'(k), 0); #1;
            n_cmp++;
            if (i_fill_r !== 1'b1) begin n_err++; $display("FAIL full_ready beat %0d got %0b want 1", k, i_fill_r); end
            step();
            n_cmp++;
            if (o_wr_ptr !== 1'(k / 8) || o_wr_clofs !== 3'(k % 8)) begin
                n_err++;
                $display("FAIL full_addr beat %0d got ptr%0d ofs%0d want ptr%0d ofs%0d", k, o_wr_ptr, o_wr_clofs, k / 8, k % 8);
            end
        end
        drive(5, 64'h55, 0); #1;
        n_cmp++;
        if (i_fill_r !== 1'b0) begin n_err++; $display("FAIL full_17_refused got %0b want 0", i_fill_r); end
        step();
        n_cmp += 2;
        if (nv(5) !== 2'd2) begin n_err++; $display("FAIL full_cnt got %0d want 2", nv(5)); end
        if (i_fill_r !== 1'b0) begin n_err++; $display("FAIL full_still_refused got %0b want 0", i_fill_r); end
        i_rel[5] = 1'b1;
        step();
        i_rel[5] = 1'b0; #1;
        n_cmp += 2;
        if (nv(5) !== 2'd1) begin n_err++; $display("FAIL full_rel_cnt got %0d want 1", nv(5)); end
        if (i_fill_r !== 1'b1) begin n_err++; $display("FAIL full_rel_ready got %0b want 1", i_fill_r); end
        step();
        n_cmp++;
        if (o_wr_v !== 1'b1 || o_wr_ptr !== 1'b0 || o_wr_clofs !== 3'd0 || o_wr_data !== 64'h55) begin
            n_err++;
            $display("FAIL full_17_write got v%0b ptr%0d ofs%0d d%0h want v1 ptr0 ofs0 d55", o_wr_v, o_wr_ptr, o_wr_clofs, o_wr_data);
        end
        $display("stream5 beat 17 ptr %0d clofs %0d", o_wr_ptr, o_wr_clofs);
        idle();
        step();
    endtask

    task automatic test_last();
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            drive(2, 64'h20 + 64'(k), (k == 2)); #1;
            n_cmp++;
            if (i_fill_r !== 1'b1) begin n_err++; $display("FAIL last_ready beat %0d got %0b want 1", k, i_fill_r); end
            step();
        end
        n_cmp++;
        if (o_wr_clofs !== 3'd2 || o_wr_data !== 64'h22) begin
            n_err++; $display("FAIL last_write got ofs%0d d%0h want ofs2 d22", o_wr_clofs, o_wr_data);
        end
        drive(2, 64'h23, 0); #1;
        n_cmp++;
        if (i_fill_r !== 1'b0) begin n_err++; $display("FAIL last_pending_refuse got %0b want 0", i_fill_r); end
        step();
        n_cmp += 4;
        if (nv(2) !== 2'd1) begin n_err++; $display("FAIL last_cnt got %0d want 1", nv(2)); end
        if (o_end[2] !== 1'b1) begin n_err++; $display("FAIL last_end got %0b want 1", o_end[2]); end
        if (o_wr_v !== 1'b0) begin n_err++; $display("FAIL last_no_extra got %0b want 0", o_wr_v); end
        if (i_fill_r !== 1'b0) begin n_err++; $display("FAIL last_end_refuse got %0b want 0", i_fill_r); end
        step();
`ifdef L1_WR_ERR_CHK_EN
        n_cmp++;
        if (o_err[2] !== 1'b1) begin n_err++; $display("FAIL last_err got %0b want 1", o_err[2]); end
`endif
        $display("stream2 end %0b cnt %0d", o_end[2], nv(2));
        idle();
    endtask

    task automatic test_back_to_back();
        int wc0;
        reset_dut();
        o_wr_r = 1'b0;
        drive(1, 64'h10, 0); #1;
        n_cmp++;
        if (i_fill_r !== 1'b1) begin n_err++; $display("FAIL stall_first_ready got %0b want 1", i_fill_r); end
        step();
        wc0 = wr_count;
        drive(1, 64'h11, 0);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp += 2;
            if (i_fill_r !== 1'b0) begin n_err++; $display("FAIL stall_ready cyc %0d got %0b want 0", c, i_fill_r); end
            if (o_wr_v !== 1'b1 || o_wr_data !== 64'h10 || o_wr_clofs !== 3'd0) begin
                n_err++; $display("FAIL stall_hold cyc %0d got v%0b d%0h ofs%0d want v1 d10 ofs0", c, o_wr_v, o_wr_data, o_wr_clofs);
            end
            step();
        end
        o_wr_r = 1'b1; #1;
        n_cmp++;
        if (i_fill_r !== 1'b1) begin n_err++; $display("FAIL stall_drain_ready got %0b want 1", i_fill_r); end
        for (int k = 1; k < 4; k++) begin
            drive(1, 64'h10 + 64'(k), 0);
            step();
            n_cmp++;
            if (o_wr_v !== 1'b1 || o_wr_data !== 64'h10 + 64'(k) || o_wr_clofs !== 3'(k)) begin
                n_err++; $display("FAIL b2b_write %0d got v%0b d%0h ofs%0d want v1 d%0h ofs%0d", k, o_wr_v, o_wr_data, o_wr_clofs, 16 + k, k);
            end
            $display("stream1 write d %0h clofs %0d", o_wr_data, o_wr_clofs);
        end
        idle();
        step();
        n_cmp += 2;
        if (o_wr_v !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %0b want 0", o_wr_v); end
        if (wr_count - wc0 !== 4) begin n_err++; $display("FAIL b2b_count got %0d want 4", wr_count - wc0); end
    endtask

    task automatic test_release();
        reset_dut();
        for (int k = 0; k < 8; k++) begin drive(4, 64'(k), 0); step(); end
        idle(); step();
        for (int k = 0; k < 8; k++) begin drive(4, 64'(k), 0); step(); end
        idle();
        i_rel[4] = 1'b1;
        step();
        i_rel[4] = 1'b0;
        n_cmp += 2;
        if (nv(4) !== 2'd1) begin n_err++; $display("FAIL rel_same_cycle got %0d want 1", nv(4)); end
        if (o_single_v[4] !== 1'b1) begin n_err++; $display("FAIL rel_single got %0b want 1", o_single_v[4]); end
        i_rel[6] = 1'b1;
        step();
        i_rel[6] = 1'b0;
        n_cmp++;
        if (nv(6) !== 2'd0) begin n_err++; $display("FAIL rel_underflow got %0d want 0", nv(6)); end
`ifdef L1_WR_ERR_CHK_EN
        n_cmp += 2;
        if (o_err[6] !== 1'b1) begin n_err++; $display("FAIL rel_err6 got %0b want 1", o_err[6]); end
        if (o_err[4] !== 1'b0) begin n_err++; $display("FAIL rel_err4 got %0b want 0", o_err[4]); end
`endif
        $display("stream4 cnt %0d stream6 cnt %0d", nv(4), nv(6));
    endtask

    task automatic test_restart();
        reset_dut();
        for (int k = 0; k < 3; k++) begin drive(7, 64'(k), 0); step(); end
        idle(); step();
        i_rst[7] = 1'b1;
        step();
        i_rst[7] = 1'b0;
        drive(7, 64'h70, 0); #1;
        n_cmp++;
        if (i_fill_r !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b want 1", i_fill_r); end
        step();
        n_cmp++;
        if (o_wr_ptr !== 1'b0 || o_wr_clofs !== 3'd0) begin
            n_err++; $display("FAIL rst_addr got ptr%0d ofs%0d want ptr0 ofs0", o_wr_ptr, o_wr_clofs);
        end
        $display("stream7 after restart ptr %0d clofs %0d", o_wr_ptr, o_wr_clofs);
        for (int k = 1; k < 8; k++) begin drive(7, 64'h70 + 64'(k), 0); step(); end
        idle(); o_wr_r = 1'b0;
        i_rst[7] = 1'b1;
        step();
        i_rst[7] = 1'b0;
        n_cmp++;
        if (o_wr_v !== 1'b1 || o_wr_clofs !== 3'd7) begin
            n_err++; $display("FAIL rst_held_beat got v%0b ofs%0d want v1 ofs7", o_wr_v, o_wr_clofs);
        end
        o_wr_r = 1'b1;
        step();
        n_cmp += 2;
        if (o_wr_v !== 1'b0) begin n_err++; $display("FAIL rst_drained got %0b want 0", o_wr_v); end
        if (nv(7) !== 2'd0) begin n_err++; $display("FAIL rst_stale_cnt got %0d want 0", nv(7)); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int k = 0; k < 8; k++) begin drive(3, 64'(k), 0); step(); end
        idle(); step();
        o_wr_r = 1'b0;
        drive(3, 64'h99, 0); step();
        reset = 1'b0;
        step();
        n_cmp += 4;
        if (o_wr_v !== 1'b0) begin n_err++; $display("FAIL mid_reset_wr_v got %0b want 0", o_wr_v); end
        if (o_nvalid !== '0) begin n_err++; $display("FAIL mid_reset_nvalid got %h want 0", o_nvalid); end
        if (o_single_v !== '0) begin n_err++; $display("FAIL mid_reset_single got %h want 0", o_single_v); end
        if (o_end !== '0) begin n_err++; $display("FAIL mid_reset_end got %h want 0", o_end); end
        idle(); reset = 1'b1; o_wr_r = 1'b1;
        $display("mid-traffic reset applied");
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_full();
        test_last();
        test_back_to_back();
        test_release();
        test_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
